// File: rtl/periph_bus_pkg.sv
// Shared constants for the peripheral bus: FSM encoding, default read latency
// and the device address map used by the master and the peripheral assembly.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int RD_LAT_DEF = 1;

  localparam logic [31:0] MAP_GUARD_LO = 32'h0;
  localparam logic [31:0] MAP_GUARD_HI = 32'h1;
  localparam logic [31:0] MUX_BASE0    = 32'h2;
  localparam logic [31:0] MUX_BASE1    = 32'h4;
  localparam logic [31:0] MUX_BASE2    = 32'h6;
  localparam logic [31:0] MUX_BASE3    = 32'h8;
  localparam logic [31:0] GPIO_BASE0   = 32'hA;
  localparam logic [31:0] GPIO_BASE1   = 32'hC;
  localparam logic [31:0] GPIO_BASE2   = 32'hE;
  localparam logic [31:0] GPIO_BASE3   = 32'h10;
  localparam logic [31:0] MAP_TOP      = 32'h11;

  // Unsigned inclusive window check; no wrap at the top of the space.
  function automatic logic addr_in_range(input logic [31:0] a,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/periph_bus_master_if.sv
// CPU request/response and peripheral bus signals of the bus master.
interface periph_bus_master_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_ack;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic [31:0] sys_w_addr;
  logic [31:0] sys_r_addr;
  logic [31:0] sys_w_line;
  logic [31:0] sys_r_line;
  logic        sys_w;
  logic        sys_r;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, sys_r_line,
    output cpu_ready, cpu_ack, cpu_err, cpu_rdata,
           sys_w_addr, sys_r_addr, sys_w_line, sys_w, sys_r
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, sys_r_line,
    input  cpu_ready, cpu_ack, cpu_err, cpu_rdata,
           sys_w_addr, sys_r_addr, sys_w_line, sys_w, sys_r
  );
endinterface

// File: rtl/periph_bus_master.sv
// Turns single CPU load/store requests into timed peripheral bus strobes and
// returns a one-cycle ack/err. Every output is registered from the next state.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = 32'h2,
  parameter logic [31:0] ADDR_HI = 32'h11,
  parameter int          RD_LAT  = RD_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  periph_bus_master_if.master bus
);

  state_t      r_state, w_nxt;
  logic [31:0] r_addr;
  logic        r_err;
  logic [3:0]  r_cnt;

  logic        r_ready, r_ack, r_err_o, r_sys_w, r_sys_r;
  logic [31:0] r_rdata, r_w_addr, r_r_addr, r_w_line;

  logic        w_ready, w_ack, w_err_o, w_sys_w, w_sys_r;
  logic [31:0] w_rdata, w_w_addr, w_r_addr, w_w_line;

  logic        w_acc, w_in_range, w_last, w_err_src;
  logic [31:0] w_addr_src;

  assign w_acc      = (r_state == IDLE) && bus.cpu_req;
  assign w_in_range = addr_in_range(bus.cpu_addr, ADDR_LO, ADDR_HI);
  assign w_last     = (r_cnt == 4'd1);
  assign w_addr_src = w_acc ? bus.cpu_addr : r_addr;
  assign w_err_src  = w_acc ? !w_in_range : r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.cpu_req) w_nxt = !w_in_range ? RESP : (bus.cpu_we ? WRITE : READ);
      WRITE:   w_nxt = RESP;
      READ:    if (w_last) w_nxt = RESP;
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered and registered with it.
  always_comb begin
    w_ready  = (w_nxt == IDLE);
    w_sys_w  = (w_nxt == WRITE);
    w_sys_r  = (w_nxt == READ);
    w_ack    = (w_nxt == RESP);
    w_err_o  = w_ack && w_err_src;
    w_w_addr = w_sys_w ? bus.cpu_addr  : 32'h0;
    w_w_line = w_sys_w ? bus.cpu_wdata : 32'h0;
    w_r_addr = w_sys_r ? w_addr_src    : 32'h0;
    w_rdata  = r_rdata;
    if (r_state == READ && w_last) w_rdata = bus.sys_r_line;
    else if (w_nxt == RESP)        w_rdata = 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= 32'h0;
      r_err  <= 1'b0;
      r_cnt  <= 4'd0;
    end else if (w_acc) begin
      r_addr <= bus.cpu_addr;
      r_err  <= !w_in_range;
      r_cnt  <= 4'(RD_LAT);
    end else if (r_state == READ) begin
      r_cnt  <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready  <= 1'b1;
      r_ack    <= 1'b0;
      r_err_o  <= 1'b0;
      r_rdata  <= 32'h0;
      r_sys_w  <= 1'b0;
      r_sys_r  <= 1'b0;
      r_w_addr <= 32'h0;
      r_r_addr <= 32'h0;
      r_w_line <= 32'h0;
    end else begin
      r_ready  <= w_ready;
      r_ack    <= w_ack;
      r_err_o  <= w_err_o;
      r_rdata  <= w_rdata;
      r_sys_w  <= w_sys_w;
      r_sys_r  <= w_sys_r;
      r_w_addr <= w_w_addr;
      r_r_addr <= w_r_addr;
      r_w_line <= w_w_line;
    end
  end

  assign bus.cpu_ready  = r_ready;
  assign bus.cpu_ack    = r_ack;
  assign bus.cpu_err    = r_err_o;
  assign bus.cpu_rdata  = r_rdata;
  assign bus.sys_w      = r_sys_w;
  assign bus.sys_r      = r_sys_r;
  assign bus.sys_w_addr = r_w_addr;
  assign bus.sys_r_addr = r_r_addr;
  assign bus.sys_w_line = r_w_line;

endmodule

// File: tb/tb_periph_bus_master.sv
// Scoreboard bench: two masters (read latency 1 and 3) share one responder value.
module tb_periph_bus_master;
  import periph_bus_pkg::*;

  localparam int RDL0 = 1;
  localparam int RDL1 = 3;

  typedef struct { logic err; logic [31:0] rdata; int t; } ack_e;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; int first; int last; } bus_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [1:0]  req = '0, we = '0;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] resp_data = 32'h0;

  logic [1:0]        s_ready, s_ack, s_err, s_w, s_r;
  logic [1:0][31:0]  s_rdata, s_waddr, s_raddr, s_wline;

  ack_e ackq [2][$];
  bus_e busq [2][$];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : gd
    periph_bus_master_if bif();
    assign bif.cpu_req    = req[g];
    assign bif.cpu_we     = we[g];
    assign bif.cpu_addr   = addr[g];
    assign bif.cpu_wdata  = wdata[g];
    assign bif.sys_r_line = resp_data;
    assign s_ready[g] = bif.cpu_ready;
    assign s_ack[g]   = bif.cpu_ack;
    assign s_err[g]   = bif.cpu_err;
    assign s_rdata[g] = bif.cpu_rdata;
    assign s_w[g]     = bif.sys_w;
    assign s_r[g]     = bif.sys_r;
    assign s_waddr[g] = bif.sys_w_addr;
    assign s_raddr[g] = bif.sys_r_addr;
    assign s_wline[g] = bif.sys_w_line;
    periph_bus_master #(.ADDR_LO(32'h2), .ADDR_HI(32'h11), .RD_LAT(g == 0 ? RDL0 : RDL1)) dut (
      .clk(clk), .rst(rst), .bus(bif.master)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever a master strobes the bus or acks.
  always @(negedge clk) begin : mon
    int   tn;
    ack_e a;
    bus_e b;
    if (!rst) begin
      tn = cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (s_w[d] && s_r[d]) chk("strobe_overlap", 32'd1, 32'd0);
        if (s_w[d]) begin
          if (busq[d].size() == 0) chk("unexpected_sys_w", 32'd1, 32'd0);
          else begin
            b = busq[d].pop_front();
            chk("w_kind", 32'd1, {31'd0, b.we});
            chk("w_time", tn, b.first);
            chk("w_addr", s_waddr[d], b.addr);
            chk("w_line", s_wline[d], b.data);
          end
        end else if (s_waddr[d] != 0 || s_wline[d] != 0) begin
          chk("w_idle_addr", s_waddr[d], 32'h0);
          chk("w_idle_line", s_wline[d], 32'h0);
        end
        if (s_r[d]) begin
          if (busq[d].size() == 0) chk("unexpected_sys_r", 32'd1, 32'd0);
          else begin
            b = busq[d][0];
            chk("r_kind", 32'd0, {31'd0, b.we});
            chk("r_addr", s_raddr[d], b.addr);
            chk("r_window", {31'd0, (tn >= b.first && tn <= b.last)}, 32'd1);
            if (tn >= b.last) void'(busq[d].pop_front());
          end
        end else if (s_raddr[d] != 0) chk("r_idle_addr", s_raddr[d], 32'h0);
        if (!s_w[d] && !s_r[d] && busq[d].size() > 0 && tn >= busq[d][0].first) begin
          chk("bus_strobe_missing", 32'd0, 32'd1);
          void'(busq[d].pop_front());
        end
        if (s_ack[d]) begin
          chk("ready_low_in_ack", {31'd0, s_ready[d]}, 32'd0);
          if (ackq[d].size() == 0) chk("spurious_ack", 32'd1, 32'd0);
          else begin
            a = ackq[d].pop_front();
            chk("ack_time", tn, a.t);
            chk("ack_err", {31'd0, s_err[d]}, {31'd0, a.err});
            chk("ack_rdata", s_rdata[d], a.rdata);
          end
        end else begin
          if (s_err[d]) chk("err_without_ack", 32'd1, 32'd0);
          if (ackq[d].size() > 0 && tn >= ackq[d][0].t) begin
            chk("ack_missing", 32'd0, 32'd1);
            void'(ackq[d].pop_front());
          end
        end
      end
    end
  end

  task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic e, input logic [31:0] rd, input bit hold, output int acc_t);
    int   n, rl;
    ack_e x;
    bus_e b;
    rl = (d == 0) ? RDL0 : RDL1;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    n = 0;
    while (!s_ready[d] && n < 50) begin @(negedge clk); n++; end
    if (!s_ready[d]) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req[d] = 1'b0;
      acc_t = -1;
      return;
    end
    acc_t   = cyc + 1;
    x.err   = e;
    x.rdata = rd;
    x.t     = acc_t + (e ? 1 : (w ? 2 : rl + 1));
    ackq[d].push_back(x);
    if (!e) begin
      b.we = w; b.addr = a; b.data = w ? wd : 32'h0;
      b.first = acc_t + 1;
      b.last  = acc_t + (w ? 1 : rl);
      busq[d].push_back(b);
    end
    @(negedge clk);
    if (!hold) req[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n = 0;
    while ((ackq[d].size() > 0 || busq[d].size() > 0) && n < 30) begin @(negedge clk); n++; end
    if (ackq[d].size() > 0 || busq[d].size() > 0) begin
      chk("drain_timeout", 32'd0, 32'd1);
      ackq[d].delete();
      busq[d].delete();
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_ready"}, {31'd0, s_ready[d]}, 32'd1);
    chk({tag, "_ack"},   {31'd0, s_ack[d]},   32'd0);
    chk({tag, "_err"},   {31'd0, s_err[d]},   32'd0);
    chk({tag, "_sys_w"}, {31'd0, s_w[d]},     32'd0);
    chk({tag, "_sys_r"}, {31'd0, s_r[d]},     32'd0);
    chk({tag, "_waddr"}, s_waddr[d], 32'h0);
    chk({tag, "_raddr"}, s_raddr[d], 32'h0);
    chk({tag, "_wline"}, s_wline[d], 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int t1, t2;
    addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_idle(d, "reset");
      chk("reset_rdata", s_rdata[d], 32'h0);
    end
    @(posedge clk); #2 rst = 1'b0;

    // Latency-1 master
    do_req(0, 1'b1, 32'hA, 32'h0000_00A5, 1'b0, 32'h0, 1'b0, t1); drain(0);
    resp_data = 32'h1234_5678;
    do_req(0, 1'b0, 32'h4, 32'h0, 1'b0, 32'h1234_5678, 1'b0, t1); drain(0);
    do_req(0, 1'b0, 32'h1, 32'h0, 1'b1, 32'h0, 1'b0, t1); drain(0);
    do_req(0, 1'b1, 32'h12, 32'h5A5A_5A5A, 1'b1, 32'h0, 1'b0, t1); drain(0);
    do_req(0, 1'b1, 32'h2, 32'h0000_0055, 1'b0, 32'h0, 1'b0, t1); drain(0);
    resp_data = 32'hDEAD_BEEF;
    do_req(0, 1'b0, 32'h11, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, t1); drain(0);
    do_req(0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b0, t1); drain(0);
    do_req(0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, t1); drain(0);

    // Back-to-back with cpu_req held high across both requests
    resp_data = 32'h0000_00FF;
    do_req(0, 1'b1, 32'h6, 32'h0000_0077, 1'b0, 32'h0, 1'b1, t1);
    do_req(0, 1'b0, 32'h6, 32'h0, 1'b0, 32'h0000_00FF, 1'b0, t2);
    chk("b2b_second_accept", t2, t1 + 3);
    drain(0);

    // Latency-3 master
    resp_data = 32'h1234_5678;
    do_req(1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h1234_5678, 1'b0, t1); drain(1);

    // Reset during the second cycle of the read hold
    resp_data = 32'h0BAD_0BAD;
    do_req(1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0BAD_0BAD, 1'b0, t1);
    @(posedge clk); #2 rst = 1'b1;
    ackq[1].delete(); busq[1].delete();
    #1;
    chk_idle(1, "midrst");
    repeat (2) @(negedge clk);
    chk("midrst_no_ack", {31'd0, s_ack[1]}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, s_ready[1]}, 32'd1);
    resp_data = 32'hCAFE_0001;
    do_req(1, 1'b0, 32'hC, 32'h0, 1'b0, 32'hCAFE_0001, 1'b0, t1); drain(1);
    do_req(1, 1'b1, 32'h10, 32'h0000_0033, 1'b0, 32'h0, 1'b0, t1); drain(1);

    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("final_ackq_empty", ackq[d].size(), 32'd0);
      chk("final_busq_empty", busq[d].size(), 32'd0);
      chk_idle(d, "final");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- Initiator end of the shared peripheral bus (sys_w_addr/sys_r_addr/sys_w_line/sys_r_line/sys_w/sys_r).
- Peripherals such as gpio and gpio_mux are responders on that bus. This block turns single CPU load/store requests into correctly timed bus strobes.
- Captures read data after a fixed latency and returns one-cycle ack/err responses.
- Sits between the CPU memory stage and the peripheral assembly.

Parameters:
- ADDR_LO, 32'h2: lowest valid peripheral word address, inclusive.
- ADDR_HI, 32'h11: highest valid peripheral word address, inclusive.
- RD_LAT, 1: cycles sys_r is held; legal 1..15; read data is sampled at the last edge of the hold.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request valid; held by CPU until accepted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  peripheral word address.
- cpu_wdata  in  32  write data.
- cpu_ready  out  1  master can accept; request accepted on edge where cpu_req & cpu_ready.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_ack; address out of range.
- cpu_rdata  out  32  read data, valid with cpu_ack on reads.
- sys_w_addr  out  32  bus write address.
- sys_r_addr  out  32  bus read address.
- sys_w_line  out  32  bus write data.
- sys_r_line  in  32  bus read data, shared by all responders.
- sys_w  out  1  write strobe.
- sys_r  out  1  read strobe.

Behaviour:
- Reset (async, active-high), state = IDLE, and all registered outputs are cleared:
  - cpu_ready = 1.
  - cpu_ack, cpu_err, cpu_rdata = 0.
  - sys_w, sys_r = 0.
  - sys_w_addr, sys_r_addr, sys_w_line = 0.
- All outputs are registered. No combinational path from cpu_* to sys_*.
- States:
  - IDLE: cpu_ready = 1.
  - WRITE, READ, RESP: cpu_ready = 0.
- Accept: IDLE with cpu_req = 1 at edge N latches we/addr/wdata and computes in_range = (ADDR_LO <= addr <= ADDR_HI), unsigned.
  - in_range & we -> WRITE.
  - in_range & !we -> READ, latency counter loaded with RD_LAT.
  - !in_range -> RESP with err = 1. No bus strobe is issued.
- WRITE (cycle N+1):
  - sys_w = 1, sys_w_addr = addr, sys_w_line = wdata.
  - Exactly one cycle, then RESP.
- READ (cycles N+1..N+RD_LAT):
  - sys_r = 1 and sys_r_addr = addr, held stable.
  - Counter decrements each cycle. At the edge where it reaches 0, sys_r_line is captured into cpu_rdata and the state goes to RESP.
- RESP (one cycle):
  - cpu_ack = 1, cpu_err = err.
  - cpu_rdata = captured data on reads; 0 on writes and on errors.
  - Next state IDLE.
- Latency:
  - write: ack at N+2.
  - read: ack at N+RD_LAT+1.
  - error: ack at N+1.
  - Next accept no earlier than ack cycle + 1.
- Idle bus:
  - Strobes are 0 outside WRITE/READ.
  - Address and data outputs return to 0 when not strobing, so no stale address reaches responder decoders.
- sys_w and sys_r are never high in the same cycle.
- cpu_req while cpu_ready = 0 is ignored; the CPU must keep holding it.
- cpu_req deasserted in IDLE: no activity.
- Boundaries:
  - addr = ADDR_LO or ADDR_HI is valid.
  - ADDR_LO-1 and ADDR_HI+1 are errors.
  - 32'hFFFFFFFF is an error; no wrap.
- Reset mid-transaction:
  - Strobes drop immediately (asynchronous) and the state returns to IDLE.
  - No ack is produced for the aborted transaction.
- cpu_rdata holds its last value except in RESP, where it is updated as above.

Decomposition:
- Shared package periph_bus_pkg holds:
  - State encoding constants: IDLE, WRITE, READ, RESP.
  - Default RD_LAT.
  - Device-map base constants: mux 0x2/0x4/0x6/0x8, gpio 0xA/0xC/0xE/0x10, guard band 0x0-0x1, map top 0x11.
  - These constants are reused by the peripheral assembly.
- Single module. No sub-module: the range check and latency counter are too small to split.

Test Plan:
- Write 0x0000_00A5 to addr 0xA at edge N:
  - sys_w = 1 only at N+1, with sys_w_addr = 0xA and sys_w_line = 0xA5.
  - cpu_ack = 1, cpu_err = 0 at N+2; cpu_ready = 1 at N+3.
- Read addr 0x4 with RD_LAT = 1 and responder driving 0x1234_5678:
  - sys_r = 1 at N+1.
  - ack at N+2 with cpu_rdata = 0x12345678.
  - Repeat with RD_LAT = 3: sys_r high N+1..N+3, ack at N+4.
- Read addr 0x1 and write addr 0x12:
  - No sys_r/sys_w pulse at any time.
  - ack + err = 1 at N+1, cpu_rdata = 0.
  - Addr 0x2 and 0x11 complete with err = 0.
- Back-to-back: cpu_req held high for write 0x6, then read 0x6 returning 0xFF:
  - Second accept only after the first ack.
  - Strobes never overlap.
  - Exactly one ack per request.
- Assert rst during the READ hold (RD_LAT = 3, second cycle):
  - sys_r = 0 before the next edge and no ack is produced.
  - After release, cpu_ready = 1 and a new read completes normally.
